id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly upstream of the ALU.
- Captures decoded operands from decode and resolves data hazards by MEM→EX and WB→EX forwarding plus load-use stall.
- Drives ALUop1/ALUop2/ALUctrl to the ALU, and carries rd/control sideband to EX/MEM.
- Refreshes held operands while stalled, so forwarded data is not lost as producers retire.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/fwd_mux.sv | 31 +++
 rtl/id_ex_stage.sv | 214 +++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared decode types for the ID/EX stage: operand-select encodings, ALU opcodes
// and the forwarding-hit helper.
package riscv_pkg;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'b00,
        SRCA_PC   = 2'b01,
        SRCA_ZERO = 2'b10
    } srca_e;

    typedef enum logic {
        SRCB_RS2 = 1'b0,
        SRCB_IMM = 1'b1
    } srcb_e;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_OR    = 4'b0111;
    localparam logic [3:0] ALU_AND   = 4'b1000;
    localparam logic [3:0] ALU_PASSB = 4'b1001;
    localparam logic [3:0] ALU_SRA   = 4'b1010;

    // A producer feeds a consumer only if it writes, targets a real register, and matches.
    function automatic logic fwd_hit(input logic       we,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
        fwd_hit = we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-source-register bypass selector: MEM result beats WB result beats held data.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int REGADDR   = 5
) (
    input  logic [REGADDR-1:0]   rs_addr,
    input  logic [DATAWIDTH-1:0] rs_data,
    input  logic                 mem_regwrite,
    input  logic [REGADDR-1:0]   mem_rd_addr,
    input  logic [DATAWIDTH-1:0] mem_result,
    input  logic                 wb_regwrite,
    input  logic [REGADDR-1:0]   wb_rd_addr,
    input  logic [DATAWIDTH-1:0] wb_result,
    output logic [DATAWIDTH-1:0] fwd_data
);

    // Youngest producer wins.
    always_comb begin
        fwd_data = rs_data;
        if (fwd_hit(mem_regwrite, mem_rd_addr, rs_addr)) begin
            fwd_data = mem_result;
        end else if (fwd_hit(wb_regwrite, wb_rd_addr, rs_addr)) begin
            fwd_data = wb_result;
        end else begin
            fwd_data = rs_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, load-use stall and held-operand refresh.
// Optional ID_EX_PERF_CNT_EN adds stall_cnt/bubble_cnt outputs.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int REGADDR   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [REGADDR-1:0]   id_rs1_addr,
    input  logic [REGADDR-1:0]   id_rs2_addr,
    input  logic [REGADDR-1:0]   id_rd_addr,
    input  logic [DATAWIDTH-1:0] id_rs1_data,
    input  logic [DATAWIDTH-1:0] id_rs2_data,
    input  logic [DATAWIDTH-1:0] id_imm,
    input  logic [DATAWIDTH-1:0] id_pc,
    input  logic [1:0]           id_srca,
    input  logic                 id_srcb,
    input  logic [3:0]           id_aluctrl,
    input  logic                 id_regwrite,
    input  logic                 id_memread,
    input  logic                 id_memwrite,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [DATAWIDTH-1:0] ALUop1,
    output logic [DATAWIDTH-1:0] ALUop2,
    output logic [3:0]           ALUctrl,
    output logic [DATAWIDTH-1:0] ex_store_data,
    output logic [REGADDR-1:0]   ex_rd_addr,
    output logic                 ex_regwrite,
    output logic                 ex_memread,
    output logic                 ex_memwrite,
    input  logic [REGADDR-1:0]   mem_rd_addr,
    input  logic [REGADDR-1:0]   wb_rd_addr,
    input  logic                 mem_regwrite,
    input  logic                 wb_regwrite,
    input  logic [DATAWIDTH-1:0] mem_result,
    input  logic [DATAWIDTH-1:0] wb_result
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          bubble_cnt
`endif
);

    logic                 valid_q, valid_d;
    logic [REGADDR-1:0]   rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
    logic [DATAWIDTH-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [DATAWIDTH-1:0] imm_q, imm_d, pc_q, pc_d;
    logic [1:0]           srca_q, srca_d;
    logic                 srcb_q, srcb_d;
    logic [3:0]           aluctrl_q, aluctrl_d;
    logic                 regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;
    logic [DATAWIDTH-1:0] fwd_rs1_s, fwd_rs2_s;
    logic                 load_use_s;

    fwd_mux #(.DATAWIDTH(DATAWIDTH), .REGADDR(REGADDR)) u_fwd_rs1 (
        .rs_addr(rs1_addr_q), .rs_data(rs1_data_q),
        .mem_regwrite(mem_regwrite), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .fwd_data(fwd_rs1_s)
    );

    fwd_mux #(.DATAWIDTH(DATAWIDTH), .REGADDR(REGADDR)) u_fwd_rs2 (
        .rs_addr(rs2_addr_q), .rs_data(rs2_data_q),
        .mem_regwrite(mem_regwrite), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .fwd_data(fwd_rs2_s)
    );

    assign load_use_s = valid_q && memread_q && (rd_addr_q != {REGADDR{1'b0}}) && id_valid &&
                        ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));
    assign id_ready   = ex_ready && !load_use_s;

    // Next-state selection in strict priority: flush, bubble, capture, drain, hold.
    always_comb begin
        valid_d    = valid_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        srca_d     = srca_q;
        srcb_d     = srcb_q;
        aluctrl_d  = aluctrl_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        if (flush || (ex_ready && load_use_s)) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
        end else if (id_valid && id_ready) begin
            valid_d    = 1'b1;
            rs1_addr_d = id_rs1_addr;
            rs2_addr_d = id_rs2_addr;
            rd_addr_d  = id_rd_addr;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            pc_d       = id_pc;
            srca_d     = id_srca;
            srcb_d     = id_srcb;
            aluctrl_d  = id_aluctrl;
            regwrite_d = id_regwrite;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
        end else if (ex_ready && !id_valid) begin
            valid_d = 1'b0;
        end else if (valid_q && !ex_ready) begin
            // Absorb forwarded values now; the producers may retire before we advance.
            rs1_data_d = fwd_rs1_s;
            rs2_data_d = fwd_rs2_s;
        end else begin
            valid_d = valid_q;
        end
    end

    // Pipeline register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs1_addr_q <= {REGADDR{1'b0}};
            rs2_addr_q <= {REGADDR{1'b0}};
            rd_addr_q  <= {REGADDR{1'b0}};
            rs1_data_q <= {DATAWIDTH{1'b0}};
            rs2_data_q <= {DATAWIDTH{1'b0}};
            imm_q      <= {DATAWIDTH{1'b0}};
            pc_q       <= {DATAWIDTH{1'b0}};
            srca_q     <= SRCA_ZERO;
            srcb_q     <= SRCB_RS2;
            aluctrl_q  <= ALU_ADD;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            srca_q     <= srca_d;
            srcb_q     <= srcb_d;
            aluctrl_q  <= aluctrl_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
        end
    end

    // Operand steering; the reserved srca code reads as zero.
    always_comb begin
        ALUop1 = {DATAWIDTH{1'b0}};
        case (srca_q)
            SRCA_RS1: ALUop1 = fwd_rs1_s;
            SRCA_PC:  ALUop1 = pc_q;
            default:  ALUop1 = {DATAWIDTH{1'b0}};
        endcase
        ALUop2 = (srcb_q == SRCB_IMM) ? imm_q : fwd_rs2_s;
    end

    assign ALUctrl       = aluctrl_q;
    assign ex_store_data = fwd_rs2_s;
    assign ex_valid      = valid_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_memread    = memread_q;
    assign ex_memwrite   = memwrite_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (id_valid && !id_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (!flush && ex_ready && load_use_s) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: capture, forwarding priority,
// load-use bubble, hold refresh, flush precedence and asynchronous reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid, id_ready;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [1:0]  id_srca;
    logic        id_srcb;
    logic [3:0]  id_aluctrl;
    logic        id_regwrite, id_memread, id_memwrite, ex_ready, ex_valid;
    logic [31:0] ALUop1, ALUop2, ex_store_data;
    logic [3:0]  ALUctrl;
    logic [4:0]  ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic        ex_regwrite, ex_memread, ex_memwrite, mem_regwrite, wb_regwrite;
    logic [31:0] mem_result, wb_result;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_srca(id_srca), .id_srcb(id_srcb), .id_aluctrl(id_aluctrl),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ALUop1(ALUop1), .ALUop2(ALUop2),
        .ALUctrl(ALUctrl), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
        .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .mem_result(mem_result), .wb_result(wb_result)
`ifdef ID_EX_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
        id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0; id_pc = 32'd0;
        id_srca = 2'b00; id_srcb = 1'b0; id_aluctrl = 4'b0000;
        id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
        mem_rd_addr = 5'd0; wb_rd_addr = 5'd0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        mem_result = 32'd0; wb_result = 32'd0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        #2;
        total++; if (ex_valid !== 1'b0) begin $display("FAIL reset_valid got=%0h exp=0", ex_valid); bad++; end
        total++; if (ALUop1 !== 32'd0 || ALUop2 !== 32'd0 || ex_store_data !== 32'd0) begin
            $display("FAIL reset_ops got=%0h/%0h/%0h exp=0/0/0", ALUop1, ALUop2, ex_store_data); bad++; end
        total++; if ({ALUctrl, ex_rd_addr, ex_regwrite, ex_memread, ex_memwrite} !== 12'd0) begin
            $display("FAIL reset_ctrl got=%0h/%0h/%0b%0b%0b exp=0", ALUctrl, ex_rd_addr, ex_regwrite, ex_memread, ex_memwrite); bad++; end
        total++; if (id_ready !== 1'b1) begin $display("FAIL reset_ready got=%0b exp=1", id_ready); bad++; end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_capture;
        // ADDI x2, x1(=5), 7
        id_valid = 1'b1; id_rs1_addr = 5'd1; id_rs1_data = 32'd5; id_imm = 32'd7;
        id_srca = 2'b00; id_srcb = 1'b1; id_aluctrl = 4'b0000; id_rd_addr = 5'd2; id_regwrite = 1'b1;
        tick();
        total++; if (ex_valid !== 1'b1) begin $display("FAIL cap_valid got=%0b exp=1", ex_valid); bad++; end
        total++; if (ALUop1 !== 32'd5 || ALUop2 !== 32'd7) begin
            $display("FAIL cap_ops got=%0h/%0h exp=5/7", ALUop1, ALUop2); bad++; end
        total++; if (ALUctrl !== 4'b0000 || ex_rd_addr !== 5'd2 || ex_regwrite !== 1'b1) begin
            $display("FAIL cap_ctrl got=%0h/%0h/%0b exp=0/2/1", ALUctrl, ex_rd_addr, ex_regwrite); bad++; end
        // back-to-back: SUB with pc as op1, rs2 as op2; store data is rs2
        id_rs2_addr = 5'd9; id_rs2_data = 32'h0000_0009; id_pc = 32'h0000_0100;
        id_srca = 2'b01; id_srcb = 1'b0; id_aluctrl = 4'b0001; id_rd_addr = 5'd3;
        tick();
        total++; if (ALUop1 !== 32'h100 || ALUop2 !== 32'h9 || ex_store_data !== 32'h9 || ALUctrl !== 4'b0001) begin
            $display("FAIL b2b_ops got=%0h/%0h/%0h/%0h exp=100/9/9/1", ALUop1, ALUop2, ex_store_data, ALUctrl); bad++; end
        // reserved srca reads as zero
        id_srca = 2'b11; id_aluctrl = 4'b1010;
        tick();
        total++; if (ALUop1 !== 32'd0 || ALUctrl !== 4'b1010 || ex_valid !== 1'b1) begin
            $display("FAIL srca_rsv got=%0h/%0h/%0b exp=0/a/1", ALUop1, ALUctrl, ex_valid); bad++; end
        id_valid = 1'b0;
        tick();
        total++; if (ex_valid !== 1'b0) begin $display("FAIL drain_valid got=%0b exp=0", ex_valid); bad++; end
    endtask

    task automatic test_forward;
        idle_inputs();
        id_valid = 1'b1; id_rs1_addr = 5'd3; id_rs1_data = 32'h11; id_rs2_addr = 5'd5; id_rs2_data = 32'h22;
        id_srca = 2'b00; id_srcb = 1'b0;
        tick();
        id_valid = 1'b0;
        mem_regwrite = 1'b1; mem_rd_addr = 5'd3; mem_result = 32'hAA;
        wb_regwrite = 1'b1;  wb_rd_addr = 5'd3;  wb_result = 32'hBB;
        #1;
        total++; if (ALUop1 !== 32'hAA) begin $display("FAIL fwd_mem_prio got=%0h exp=aa", ALUop1); bad++; end
        mem_rd_addr = 5'd0;
        #1;
        total++; if (ALUop1 !== 32'hBB) begin $display("FAIL fwd_mem_x0 got=%0h exp=bb", ALUop1); bad++; end
        wb_rd_addr = 5'd5;
        #1;
        total++; if (ALUop1 !== 32'h11 || ALUop2 !== 32'hBB || ex_store_data !== 32'hBB) begin
            $display("FAIL fwd_wb_rs2 got=%0h/%0h/%0h exp=11/bb/bb", ALUop1, ALUop2, ex_store_data); bad++; end
        wb_regwrite = 1'b0;
        #1;
        total++; if (ALUop2 !== 32'h22) begin $display("FAIL fwd_wb_off got=%0h exp=22", ALUop2); bad++; end
        // rs1 = x0 must never be forwarded
        idle_inputs();
        id_valid = 1'b1; id_rs1_data = 32'h77;
        tick();
        id_valid = 1'b0;
        wb_regwrite = 1'b1; wb_rd_addr = 5'd0; wb_result = 32'hDEAD;
        mem_regwrite = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'hBEEF;
        #1;
        total++; if (ALUop1 !== 32'h77) begin $display("FAIL fwd_x0 got=%0h exp=77", ALUop1); bad++; end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_use;
        idle_inputs();
        // LW x4, 0(x1)
        id_valid = 1'b1; id_rs1_addr = 5'd1; id_rs1_data = 32'h40; id_srcb = 1'b1;
        id_rd_addr = 5'd4; id_memread = 1'b1; id_regwrite = 1'b1;
        tick();
        // ADD x7, x1, x4
        id_rs2_addr = 5'd4; id_rs2_data = 32'h0; id_srcb = 1'b0; id_rd_addr = 5'd7; id_memread = 1'b0;
        #1;
        total++; if (id_ready !== 1'b0) begin $display("FAIL lu_ready got=%0b exp=0", id_ready); bad++; end
        tick();
        total++; if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_regwrite !== 1'b0) begin
            $display("FAIL lu_bubble got=%0b/%0b/%0b exp=0/0/0", ex_valid, ex_memread, ex_regwrite); bad++; end
        total++; if (id_ready !== 1'b1) begin $display("FAIL lu_release got=%0b exp=1", id_ready); bad++; end
        mem_regwrite = 1'b1; mem_rd_addr = 5'd4; mem_result = 32'h1234;
        tick();
        id_valid = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b1 || ALUop2 !== 32'h1234 || ex_rd_addr !== 5'd7 || ALUop1 !== 32'h40) begin
            $display("FAIL lu_capture got=%0b/%0h/%0h/%0h exp=1/1234/7/40", ex_valid, ALUop2, ex_rd_addr, ALUop1); bad++; end
`ifdef ID_EX_PERF_CNT_EN
        total++; if (stall_cnt !== 32'd1 || bubble_cnt !== 32'd1) begin
            $display("FAIL perf_cnt got=%0d/%0d exp=1/1", stall_cnt, bubble_cnt); bad++; end
`endif
        idle_inputs();
        tick();
    endtask

    task automatic test_hold_refresh;
        idle_inputs();
        id_valid = 1'b1; id_rs1_addr = 5'd6; id_rs1_data = 32'h10; id_imm = 32'h3; id_srcb = 1'b1;
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        wb_regwrite = 1'b1; wb_rd_addr = 5'd6; wb_result = 32'h55;
        #1;
        total++; if (ALUop1 !== 32'h55) begin $display("FAIL hold_c1 got=%0h exp=55", ALUop1); bad++; end
        tick();
        wb_regwrite = 1'b0; wb_result = 32'h0;
        id_valid = 1'b1; id_rs1_addr = 5'd8;
        #1;
        total++; if (ALUop1 !== 32'h55 || ex_valid !== 1'b1 || id_ready !== 1'b0) begin
            $display("FAIL hold_c2 got=%0h/%0b/%0b exp=55/1/0", ALUop1, ex_valid, id_ready); bad++; end
        tick();
        total++; if (ALUop1 !== 32'h55 || ALUop2 !== 32'h3) begin
            $display("FAIL hold_c3 got=%0h/%0h exp=55/3", ALUop1, ALUop2); bad++; end
        id_valid = 1'b0; ex_ready = 1'b1;
        #1;
        total++; if (ALUop1 !== 32'h55 || id_ready !== 1'b1) begin
            $display("FAIL hold_release got=%0h/%0b exp=55/1", ALUop1, id_ready); bad++; end
        tick();
    endtask

    task automatic test_flush_reset;
        idle_inputs();
        id_valid = 1'b1; id_rd_addr = 5'd9; id_regwrite = 1'b1;
        tick();
        flush = 1'b1; id_rd_addr = 5'd10;
        #1;
        total++; if (id_ready !== 1'b1) begin $display("FAIL flush_ready got=%0b exp=1", id_ready); bad++; end
        tick();
        total++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
            $display("FAIL flush_kill got=%0b/%0b exp=0/0", ex_valid, ex_regwrite); bad++; end
        flush = 1'b0;
        id_rs1_addr = 5'd2; id_rs1_data = 32'h33; id_rs2_addr = 5'd3; id_rs2_data = 32'h66;
        id_imm = 32'h44; id_srcb = 1'b1; id_aluctrl = 4'b0111; id_memwrite = 1'b1;
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        tick();
        total++; if (ALUop1 !== 32'h33 || ALUop2 !== 32'h44 || ex_store_data !== 32'h66 || ex_valid !== 1'b1) begin
            $display("FAIL pre_rst got=%0h/%0h/%0h/%0b exp=33/44/66/1", ALUop1, ALUop2, ex_store_data, ex_valid); bad++; end
        #2;
        rst = 1'b1;
        #1;
        total++; if (ex_valid !== 1'b0 || ALUop1 !== 32'd0 || ALUop2 !== 32'd0 || ex_store_data !== 32'd0) begin
            $display("FAIL async_rst_ops got=%0b/%0h/%0h/%0h exp=0/0/0/0", ex_valid, ALUop1, ALUop2, ex_store_data); bad++; end
        total++; if ({ALUctrl, ex_rd_addr, ex_regwrite, ex_memread, ex_memwrite} !== 12'd0) begin
            $display("FAIL async_rst_ctrl got=%0h/%0h/%0b%0b%0b exp=0", ALUctrl, ex_rd_addr, ex_regwrite, ex_memread, ex_memwrite); bad++; end
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_capture();
        test_forward();
        test_load_use();
        test_hold_refresh();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
